// File: rtl/fan_pkg.sv
// Shared types and default constants for the fan tachometer monitors.
// The optional input glitch filter is enabled with FAN_TACH_GLITCH_FILTER_EN.
package fan_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } fan_state_e;

  localparam int unsigned FAN_WINDOW_CYCLES = 25000000;
  localparam int unsigned FAN_CNT_W         = 16;
  localparam int unsigned FAN_STALL_WINDOWS = 3;
  localparam int unsigned FAN_FILT_LEN      = 4;
  localparam int unsigned FAN_NUM           = 3;

  // Wide enough for the largest legal stall threshold (15).
  localparam int unsigned FAN_STALL_W       = 4;

endpackage : fan_pkg

// File: rtl/tach_sync_filter.sv
// Tach input conditioning: 2-flop synchroniser, optional stability filter
// (FAN_TACH_GLITCH_FILTER_EN) and a registered rising-edge detector.
module tach_sync_filter
  import fan_pkg::*;
`ifdef FAN_TACH_GLITCH_FILTER_EN
#(
  parameter int unsigned FILT_LEN = FAN_FILT_LEN
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_tach,
  output logic o_rise
);

  logic r_meta;
  logic r_sync_q;
  logic r_level_q;
  logic r_rise;
  logic w_level;

`ifdef FAN_TACH_GLITCH_FILTER_EN
  localparam int unsigned FC_W = $clog2(FILT_LEN) + 1;

  logic [FC_W-1:0] r_filt_cnt;
  logic            r_filt;

  // The filtered level only follows the synchroniser once the new value
  // has been seen on FILT_LEN consecutive cycles; any bounce restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt_cnt <= '0;
      r_filt     <= 1'b0;
    end else if (r_sync_q == r_filt) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FC_W'(FILT_LEN - 1)) begin
      r_filt_cnt <= '0;
      r_filt     <= r_sync_q;
    end else begin
      r_filt_cnt <= r_filt_cnt + FC_W'(1);
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, forming a true pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta    <= 1'b0;
      r_sync_q  <= 1'b0;
      r_level_q <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_meta    <= i_tach;
      r_sync_q  <= r_meta;
      r_level_q <= w_level;
      r_rise    <= w_level & ~r_level_q;
    end
  end

  assign o_rise = r_rise;

endmodule : tach_sync_filter

// File: rtl/fan_tach_monitor.sv
// Per-fan tachometer monitor: counts tach rising edges over a fixed window
// and flags a stall; optional input filter via FAN_TACH_GLITCH_FILTER_EN.
module fan_tach_monitor
  import fan_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = FAN_WINDOW_CYCLES,
  parameter int unsigned CNT_W         = FAN_CNT_W,
  parameter int unsigned STALL_WINDOWS = FAN_STALL_WINDOWS,
  parameter int unsigned FILT_LEN      = FAN_FILT_LEN
) (
  input  logic             CPLD_CLK_25M,
  input  logic             CPLD_HW_RSTN,
  input  logic             tach_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] tach_cnt,
  output logic             cnt_valid,
  output logic             fan_stall,
  output logic             win_active
);

  localparam int unsigned            WIN_W     = $clog2(WINDOW_CYCLES);
  localparam logic [WIN_W-1:0]       WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]       CNT_MAX   = '1;
  localparam logic [FAN_STALL_W-1:0] STALL_LIM = FAN_STALL_W'(STALL_WINDOWS);

  if (WINDOW_CYCLES < 4) begin : g_bad_window
    $error("fan_tach_monitor: WINDOW_CYCLES must be at least 4");
  end
  if (STALL_WINDOWS < 1 || STALL_WINDOWS > 15) begin : g_bad_stall
    $error("fan_tach_monitor: STALL_WINDOWS must be within 1..15");
  end
  if (FILT_LEN < 1) begin : g_bad_filt
    $error("fan_tach_monitor: FILT_LEN must be at least 1");
  end

  logic w_rise;

`ifdef FAN_TACH_GLITCH_FILTER_EN
  tach_sync_filter #(
    .FILT_LEN (FILT_LEN)
  ) u_tach_sync (
    .clk    (CPLD_CLK_25M),
    .rst_n  (CPLD_HW_RSTN),
    .i_tach (tach_in),
    .o_rise (w_rise)
  );
`else
  tach_sync_filter u_tach_sync (
    .clk    (CPLD_CLK_25M),
    .rst_n  (CPLD_HW_RSTN),
    .i_tach (tach_in),
    .o_rise (w_rise)
  );
`endif

  fan_state_e             r_state;
  logic [WIN_W-1:0]       r_win_cnt;
  logic [CNT_W-1:0]       r_acc;
  logic [CNT_W-1:0]       r_tach_cnt;
  logic [FAN_STALL_W-1:0] r_stall_cnt;
  logic                   r_cnt_valid;
  logic                   r_fan_stall;
  logic                   r_win_active;

  logic                   w_terminal;
  logic [CNT_W-1:0]       w_sum;
  logic [FAN_STALL_W-1:0] w_stall_next;

  // The edge arriving in the terminal cycle still belongs to the closing window.
  assign w_terminal   = (r_win_cnt == WIN_LAST);
  assign w_sum        = (r_acc == CNT_MAX) ? CNT_MAX : r_acc + CNT_W'(w_rise);
  assign w_stall_next = (w_sum != '0)              ? '0        :
                        (r_stall_cnt == STALL_LIM) ? STALL_LIM :
                                                     r_stall_cnt + FAN_STALL_W'(1);

  always_ff @(posedge CPLD_CLK_25M or negedge CPLD_HW_RSTN) begin
    if (!CPLD_HW_RSTN) begin
      r_state      <= ST_IDLE;
      r_win_cnt    <= '0;
      r_acc        <= '0;
      r_tach_cnt   <= '0;
      r_stall_cnt  <= '0;
      r_cnt_valid  <= 1'b0;
      r_fan_stall  <= 1'b0;
      r_win_active <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_win_cnt   <= '0;
          r_acc       <= '0;
          r_cnt_valid <= 1'b0;
          if (meas_en) begin
            r_state      <= ST_MEASURE;
            r_win_active <= 1'b1;
          end
        end

        ST_MEASURE: begin
          if (!meas_en) begin
            // Disable beats a coincident terminal count: partial window dropped.
            r_state      <= ST_IDLE;
            r_win_active <= 1'b0;
            r_win_cnt    <= '0;
            r_acc        <= '0;
            r_tach_cnt   <= '0;
            r_stall_cnt  <= '0;
            r_fan_stall  <= 1'b0;
            r_cnt_valid  <= 1'b0;
          end else if (w_terminal) begin
            r_win_cnt   <= '0;
            r_acc       <= '0;
            r_tach_cnt  <= w_sum;
            r_stall_cnt <= w_stall_next;
            r_fan_stall <= (w_stall_next == STALL_LIM);
            r_cnt_valid <= 1'b1;
          end else begin
            r_win_cnt   <= r_win_cnt + WIN_W'(1);
            r_acc       <= w_sum;
            r_cnt_valid <= 1'b0;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_win_active <= 1'b0;
          r_cnt_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign tach_cnt   = r_tach_cnt;
  assign cnt_valid  = r_cnt_valid;
  assign fan_stall  = r_fan_stall;
  assign win_active = r_win_active;

endmodule : fan_tach_monitor

// File: tb/tb_fan_tach_monitor.sv
// Directed bench for fan_tach_monitor: per-window expected counts go into a
// scoreboard queue and are popped on each cnt_valid strobe.
module tb_fan_tach_monitor;

  localparam int WIN    = 100;
  localparam int CW     = 8;
  localparam int SW     = 3;
  localparam int FL     = 4;
  localparam int SAT_CW = 4;
  localparam int SAT_MX = 15;

`ifdef FAN_TACH_GLITCH_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif

  typedef enum int {P_ZERO, P_SQUARE, P_SINGLE, P_TOGGLE, P_GLITCH, P_WIDE} pat_e;
  typedef struct {
    int cnt;
    bit stall;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tach_in;
  logic              meas_en;
  logic [CW-1:0]     tach_cnt;
  logic              cnt_valid, fan_stall, win_active;
  logic [SAT_CW-1:0] sat_cnt;
  logic              sat_valid, sat_stall, sat_active;

  always #20 clk = ~clk;

  fan_tach_monitor #(
    .WINDOW_CYCLES (WIN), .CNT_W (CW), .STALL_WINDOWS (SW), .FILT_LEN (FL)
  ) dut (
    .CPLD_CLK_25M (clk), .CPLD_HW_RSTN (rst_n), .tach_in (tach_in), .meas_en (meas_en),
    .tach_cnt (tach_cnt), .cnt_valid (cnt_valid), .fan_stall (fan_stall), .win_active (win_active)
  );

  // Narrow accumulator so a realistic window can hit saturation.
  fan_tach_monitor #(
    .WINDOW_CYCLES (WIN), .CNT_W (SAT_CW), .STALL_WINDOWS (SW), .FILT_LEN (FL)
  ) dut_sat (
    .CPLD_CLK_25M (clk), .CPLD_HW_RSTN (rst_n), .tach_in (tach_in), .meas_en (meas_en),
    .tach_cnt (sat_cnt), .cnt_valid (sat_valid), .fan_stall (sat_stall), .win_active (sat_active)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   stall_run = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (cnt_valid === 1'b1) begin
      check("strobe_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("tach_cnt", tach_cnt, e.cnt);
        check("fan_stall", fan_stall, e.stall);
        check("sat_valid", sat_valid, 1);
        check("sat_cnt", sat_cnt, (e.cnt > SAT_MX) ? SAT_MX : e.cnt);
      end
    end
  endtask

  function automatic logic pat_level(input pat_e m, input int i);
    case (m)
      P_SQUARE: return (i % 10) < 5;
      P_SINGLE: return (i >= 40) && (i <= 44);
      P_TOGGLE: return (i < 90) && ((i % 2) == 1);
      P_GLITCH: return ((i % 10) == 5) || ((i % 10) == 6);
      P_WIDE:   return ((i % 20) >= 5) && ((i % 20) <= 12);
      default:  return 1'b0;
    endcase
  endfunction

  // Rising edges per window; 1-cycle and 2-cycle pulses vanish behind the filter.
  function automatic int pat_count(input pat_e m);
    case (m)
      P_SQUARE: return 10;
      P_SINGLE: return 1;
      P_TOGGLE: return FILT_ON ? 0 : 45;
      P_GLITCH: return FILT_ON ? 0 : 10;
      P_WIDE:   return 5;
      default:  return 0;
    endcase
  endfunction

  task automatic run_window(input pat_e m);
    exp_t e;
    e.cnt = pat_count(m);
    if (e.cnt == 0) begin
      if (stall_run < SW) stall_run++;
    end else begin
      stall_run = 0;
    end
    e.stall = (stall_run == SW);
    sb.push_back(e);
    for (int i = 0; i < WIN; i++) begin
      tach_in = pat_level(m, i);
      step();
    end
    check("strobe_seen", sb.size(), 0);
  endtask

  task automatic enable();
    tach_in = 1'b0;
    meas_en = 1'b1;
    step();
    check("win_active_on", win_active, 1);
  endtask

  task automatic abort_mid(input pat_e m);
    for (int i = 0; i < WIN / 2; i++) begin
      tach_in = pat_level(m, i);
      step();
    end
    tach_in = 1'b0;
    meas_en = 1'b0;
    step();
    check("abort_cnt_valid", cnt_valid, 0);
    check("abort_tach_cnt", tach_cnt, 0);
    check("abort_win_active", win_active, 0);
    check("abort_fan_stall", fan_stall, 0);
    stall_run = 0;
    repeat (8) step();
  endtask

  initial begin
    rst_n   = 1'b0;
    meas_en = 1'b0;
    tach_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tach_cnt", tach_cnt, 0);
    check("rst_cnt_valid", cnt_valid, 0);
    check("rst_fan_stall", fan_stall, 0);
    check("rst_win_active", win_active, 0);
    rst_n = 1'b1;
    repeat (5) step();
    check("idle_win_active", win_active, 0);

    // Nominal spinning fan, then saturation and filter-sensitive patterns.
    enable();
    repeat (3) run_window(P_SQUARE);
    repeat (2) run_window(P_TOGGLE);
    run_window(P_GLITCH);
    run_window(P_WIDE);

    // Stall after three empty windows; one pulse clears it.
    repeat (4) run_window(P_ZERO);
    run_window(P_SINGLE);

    // Mid-window disable after a non-zero count, then a clean restart.
    run_window(P_SQUARE);
    abort_mid(P_SQUARE);
    enable();
    run_window(P_SQUARE);

    // Disable while stalled must also clear the stall history.
    repeat (3) run_window(P_ZERO);
    abort_mid(P_ZERO);
    enable();
    repeat (2) run_window(P_ZERO);
    run_window(P_SQUARE);

    // Asynchronous reset mid-window with a rising edge in the synchroniser.
    run_window(P_SQUARE);
    for (int i = 0; i < WIN / 2; i++) begin
      tach_in = pat_level(P_SQUARE, i);
      step();
    end
    tach_in = 1'b1;
    #5 rst_n = 1'b0;
    #1;
    check("arst_tach_cnt", tach_cnt, 0);
    check("arst_cnt_valid", cnt_valid, 0);
    check("arst_fan_stall", fan_stall, 0);
    check("arst_win_active", win_active, 0);
    @(negedge clk);
    meas_en = 1'b0;
    tach_in = 1'b0;
    rst_n   = 1'b1;
    stall_run = 0;
    repeat (6) step();
    check("post_rst_win_active", win_active, 0);
    enable();
    run_window(P_SQUARE);
    run_window(P_WIDE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fan_tach_monitor
